pc_fetch_sequencer: RTL

- Program-counter register and fetch sequencer for the instruction-fetch address generator.
- Sits directly upstream of the PC adder: drives the current PC into the adder and registers the adder's PC+4 result as the next sequential PC.
- Also issues instruction-memory requests with a req/ack handshake, handles redirects (branch/jump), and presents fetched instructions to decode with a valid/ready handshake.

---
 rtl/pc_fetch_sequencer_pkg.sv | 10 +
 rtl/pc_fetch_sequencer_pc_reg.sv | 62 ++++++
 rtl/pc_fetch_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared constants for the fetch address generator:
// FSM encoding, reset PC and instruction width.
package pc_fetch_sequencer_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// PC register with deferred-redirect tracking
// (redir_pc/kill) for redirects that arrive mid-request.
module pc_fetch_sequencer_pc_reg #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              ack_i,
  input  logic              redir_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] sum_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              kill_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] tgt;
  logic              pend;

  assign tgt  = {target_i[ADDR_W-1:2], 2'b00};
  assign pend = req_i & ~ack_i;

  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    kill_d  = kill_q;
    unique case (1'b1)
      redir_i & ~pend: begin
        pc_d   = tgt;
        kill_d = 1'b0;
      end
      // request in flight: keep its address, apply later
      redir_i & pend: begin
        redir_d = tgt;
        kill_d  = 1'b1;
      end
      ~redir_i & req_i & ack_i: begin
        pc_d   = kill_q ? redir_q : sum_i;
        kill_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      kill_q  <= kill_d;
    end
  end

  assign pc_o   = pc_q;
  assign kill_o = kill_q;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: IDLE/REQ/HOLD FSM driving imem
// req/ack and the decode-facing valid/ready output.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int ADDR_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_to_adder,
  input  logic [ADDR_W-1:0] adder_sum,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_instr
);
  logic [1:0]        state_q, state_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic              in_req;

  assign in_req = (state_q == ST_REQ);

  pc_fetch_sequencer_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC[ADDR_W-1:0])
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (in_req),
    .ack_i    (imem_ack),
    .redir_i  (redirect_valid),
    .target_i (redirect_target),
    .sum_i    (adder_sum),
    .pc_o     (pc),
    .kill_o   (kill)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    ins_d   = ins_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack && !kill && !redirect_valid) begin
          ipc_d   = pc;
          ins_d   = imem_rdata;
          vld_d   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      // redirect drops the held instruction
      ST_HOLD: begin
        if (redirect_valid || if_ready) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      ipc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      ins_q   <= ins_d;
    end
  end

  assign pc_to_adder = pc;
  assign imem_req    = in_req;
  assign imem_addr   = pc;
  assign if_valid    = vld_q;
  assign if_pc       = ipc_q;
  assign if_instr    = ins_q;
endmodule
